uivid_chk: RTL

- Receive-side counterpart of the video test-pattern generator: sits at the sink end of a vs/hs/de + 24-bit RGB stream (e.g. after a VDMA, scaler or camera path).
- Measures active frame geometry, counts frames, checks every active pixel against a selected expected pattern, and reports per-frame pass/fail plus a lock indication.
- Used as a self-check at the end of the video pipeline.

---
 rtl/uivid_pkg.sv | 19 +
 rtl/uivid_pat_exp.sv | 35 +++
 rtl/uivid_chk.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uivid_pkg.sv
// Shared definitions for the video stream checker: pattern mode codes,
// checker state type and the grid cell bit used by the pattern generator.
package uivid_pkg;

  localparam logic [2:0] MODE_OFF   = 3'd0;
  localparam logic [2:0] MODE_SOLID = 3'd1;
  localparam logic [2:0] MODE_GRID  = 3'd2;
  localparam logic [2:0] MODE_HRAMP = 3'd3;
  localparam logic [2:0] MODE_VRAMP = 3'd4;

  // Grid cells are 16x16 pixels: colour flips when bit 4 of x or y flips.
  localparam int GRID_BIT = 4;

  typedef enum logic {
    WAIT_VS = 1'b0,
    FRAME   = 1'b1
  } chkState_t;

endpackage

// File: rtl/uivid_pat_exp.sv
// Combinational expected-pixel generator. Given the pixel position and the
// pattern mode it returns the {R,G,B} value a correct source would produce.
// Unknown modes (off, 5-7) yield black; the caller decides whether to compare.
module uivid_pat_exp
  import uivid_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic [CNT_W-1:0] i_x,
  input  logic [CNT_W-1:0] i_y,
  input  logic [2:0]       i_mode,
  input  logic [23:0]      i_color,
  output logic [23:0]      o_pixel
);

  logic w_gridDark;
  logic w_unusedBits;

  // Only the low byte and the grid bit of each coordinate shape the pattern.
  assign w_unusedBits = ^{i_x[CNT_W-1:8], i_y[CNT_W-1:8]};

  // Select the pattern value for the current position.
  always_comb begin
    w_gridDark = i_y[GRID_BIT] ^ i_x[GRID_BIT];
    o_pixel    = 24'h000000;
    case (i_mode)
      MODE_SOLID: o_pixel = i_color;
      MODE_GRID:  o_pixel = w_gridDark ? 24'h000000 : 24'hFFFFFF;
      MODE_HRAMP: o_pixel = {3{i_x[7:0]}};
      MODE_VRAMP: o_pixel = {3{i_y[7:0]}};
      default:    o_pixel = 24'h000000;
    endcase
  end

endmodule

// File: rtl/uivid_chk.sv
// Sink-side video stream checker. Tracks the active window of each frame,
// compares every active pixel against the selected reference pattern and
// reports geometry, per-frame pass/fail, a running error count and a lock
// flag once two consecutive frames agree on their geometry.
module uivid_chk
  import uivid_pkg::*;
#(
  parameter int CNT_W  = 12,
  parameter int ERR_W  = 16,
  parameter int FCNT_W = 16
) (
  input  logic              chk_clk_i,
  input  logic              chk_rst_i,
  input  logic              chk_clr_i,
  input  logic [2:0]        cfg_mode_i,
  input  logic [23:0]       cfg_color_i,
  input  logic              vid_vs_i,
  input  logic              vid_hs_i,
  input  logic              vid_de_i,
  input  logic [23:0]       vid_data_i,
  output logic [CNT_W-1:0]  h_active_o,
  output logic [CNT_W-1:0]  v_active_o,
  output logic [FCNT_W-1:0] frame_cnt_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic              frame_done_o,
  output logic              frame_err_o,
  output logic              locked_o
);

  chkState_t         r_state;
  logic              r_vs;
  logic              r_de;
  logic [2:0]        r_mode;
  logic [23:0]       r_color;
  logic [CNT_W-1:0]  r_x;
  logic [CNT_W-1:0]  r_y;
  logic [CNT_W-1:0]  r_refWidth;
  logic              r_refValid;
  logic              r_pixErr;
  logic              r_lenErr;
  logic              r_protoErr;
  logic [CNT_W-1:0]  r_hActive;
  logic [CNT_W-1:0]  r_vActive;
  logic [FCNT_W-1:0] r_frameCnt;
  logic [ERR_W-1:0]  r_errCnt;
  logic              r_frameDone;
  logic              r_frameErr;
  logic              r_locked;

  logic              w_vsRise;
  logic              w_deFall;
  logic              w_modeOn;
  logic              w_pixMiss;
  logic              w_lockOk;
  logic [23:0]       w_expPix;
  logic              w_unusedHs;

  // Horizontal sync carries no information the checker needs; lines are
  // delimited by data enable alone.
  assign w_unusedHs = vid_hs_i;

  assign w_vsRise  = vid_vs_i & ~r_vs;
  assign w_deFall  = ~vid_de_i & r_de;
  assign w_modeOn  = (r_mode >= MODE_SOLID) && (r_mode <= MODE_VRAMP);
  assign w_pixMiss = vid_de_i && w_modeOn && (vid_data_i != w_expPix);

  // A closing frame is "stable" when it repeats the previously reported
  // geometry, is non-empty and had uniform line lengths. Outputs are zero
  // after reset, so the first close can never qualify.
  assign w_lockOk = (r_refWidth == r_hActive) && (r_y == r_vActive) &&
                    (r_refWidth != '0) && (r_y != '0) && !r_lenErr;

  assign h_active_o   = r_hActive;
  assign v_active_o   = r_vActive;
  assign frame_cnt_o  = r_frameCnt;
  assign err_cnt_o    = r_errCnt;
  assign frame_done_o = r_frameDone;
  assign frame_err_o  = r_frameErr;
  assign locked_o     = r_locked;

  uivid_pat_exp #(
    .CNT_W (CNT_W)
  ) u_patExp (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_mode  (r_mode),
    .i_color (r_color),
    .o_pixel (w_expPix)
  );

  // Delayed copies of vs and de used for edge detection.
  always_ff @(posedge chk_clk_i) begin
    if (chk_rst_i) begin
      r_vs <= 1'b0;
      r_de <= 1'b0;
    end else begin
      r_vs <= vid_vs_i;
      r_de <= vid_de_i;
    end
  end

  // Checker FSM: position tracking, per-frame flags, frame close reporting
  // and the error/frame counters. A vs rise always starts a fresh frame; the
  // traffic on that exact cycle belongs to neither frame and is not checked.
  always_ff @(posedge chk_clk_i) begin
    if (chk_rst_i) begin
      r_state     <= WAIT_VS;
      r_mode      <= MODE_OFF;
      r_color     <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_refWidth  <= '0;
      r_refValid  <= 1'b0;
      r_pixErr    <= 1'b0;
      r_lenErr    <= 1'b0;
      r_protoErr  <= 1'b0;
      r_hActive   <= '0;
      r_vActive   <= '0;
      r_frameCnt  <= '0;
      r_errCnt    <= '0;
      r_frameDone <= 1'b0;
      r_frameErr  <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      if (w_vsRise) begin
        if (r_state == FRAME) begin
          r_hActive   <= r_refWidth;
          r_vActive   <= r_y;
          r_frameCnt  <= r_frameCnt + 1'b1;
          r_frameDone <= 1'b1;
          r_frameErr  <= r_pixErr | r_lenErr | r_protoErr;
          r_locked    <= w_lockOk;
        end
        r_state    <= FRAME;
        r_mode     <= cfg_mode_i;
        r_color    <= cfg_color_i;
        r_x        <= '0;
        r_y        <= '0;
        r_refWidth <= '0;
        r_refValid <= 1'b0;
        r_pixErr   <= 1'b0;
        r_lenErr   <= 1'b0;
        r_protoErr <= 1'b0;
      end else if (r_state == FRAME) begin
        if (vid_de_i) begin
          if (r_x != '1) begin
            r_x <= r_x + 1'b1;
          end
        end else if (w_deFall) begin
          r_x <= '0;
          if (r_y != '1) begin
            r_y <= r_y + 1'b1;
          end
          if (!r_refValid) begin
            r_refWidth <= r_x;
            r_refValid <= 1'b1;
          end else if (r_x != r_refWidth) begin
            r_lenErr <= 1'b1;
          end
        end
        if (vid_de_i && vid_vs_i) begin
          r_protoErr <= 1'b1;
        end
        if (w_pixMiss) begin
          r_pixErr <= 1'b1;
          if (r_errCnt != '1) begin
            r_errCnt <= r_errCnt + 1'b1;
          end
        end
      end
      if (chk_clr_i) begin
        r_errCnt   <= '0;
        r_frameCnt <= '0;
      end
    end
  end

endmodule
